// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and constants for the RISC_SPM boot loader
package spm_pkg;

    localparam int SPM_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } boot_state_t;

endpackage

// File: rtl/spm_boot_loader_if.sv
// rtl/spm_boot_loader_if.sv - host, core and SRAM signals around the boot loader
interface spm_boot_loader_if #(
    parameter int word_size = spm_pkg::SPM_WORD_SIZE
);
    logic                 load_start;
    logic [word_size-1:0] load_base;
    logic [word_size-1:0] load_len;
    logic [word_size-1:0] host_data;
    logic                 host_valid;
    logic                 host_ready;
    logic                 cpu_rst;
    logic [word_size-1:0] cpu_address;
    logic [word_size-1:0] cpu_data_in;
    logic                 cpu_write;
    logic [word_size-1:0] cpu_data_out;
    logic [word_size-1:0] mem_address;
    logic [word_size-1:0] mem_data_in;
    logic                 mem_write;
    logic [word_size-1:0] mem_data_out;
    logic                 busy;
    logic                 done;

    // the loader itself
    modport slave (
        input  load_start, load_base, load_len, host_data, host_valid,
        input  cpu_address, cpu_data_in, cpu_write, mem_data_out,
        output host_ready, cpu_rst, cpu_data_out, mem_address, mem_data_in,
        output mem_write, busy, done
    );

    // host, core and SRAM seen together
    modport master (
        output load_start, load_base, load_len, host_data, host_valid,
        output cpu_address, cpu_data_in, cpu_write, mem_data_out,
        input  host_ready, cpu_rst, cpu_data_out, mem_address, mem_data_in,
        input  mem_write, busy, done
    );
endinterface

// File: rtl/spm_boot_loader.sv
// rtl/spm_boot_loader.sv - holds RISC_SPM in reset, streams a program into SRAM, then hands the port to the core
module spm_boot_loader
    import spm_pkg::*;
#(
    parameter int word_size      = SPM_WORD_SIZE,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    spm_boot_loader_if.slave   bus
);

    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    boot_state_t          state_q, state_d;
    logic [word_size-1:0] addr_cnt_q, addr_cnt_d;
    logic [word_size-1:0] remain_q, remain_d;
    logic [REL_W-1:0]     rel_cnt_q, rel_cnt_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 host_ready_q, host_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 beat;

    assign beat = bus.host_valid & host_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_cnt_q   <= '0;
            remain_q     <= '0;
            rel_cnt_q    <= '0;
            cpu_rst_q    <= 1'b0;
            host_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            remain_q     <= remain_d;
            rel_cnt_q    <= rel_cnt_d;
            cpu_rst_q    <= cpu_rst_d;
            host_ready_q <= host_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        remain_d   = remain_q;
        rel_cnt_d  = '0;
        case (state_q)
            IDLE, RUN: begin
                // a zero-length request just restarts the core on the current image
                if (bus.load_start) begin
                    if (bus.load_len != '0) begin
                        state_d    = LOAD;
                        addr_cnt_d = bus.load_base;
                        remain_d   = bus.load_len;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == word_size'(1)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    state_d = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // status flags are registered from the next state so they change with it
    always_comb begin
        cpu_rst_d    = (state_d == RUN);
        host_ready_d = (state_d == LOAD);
        busy_d       = (state_d == LOAD) || (state_d == RELEASE);
        done_d       = (state_d == RUN);

        bus.mem_address = addr_cnt_q;
        bus.mem_data_in = bus.host_data;
        bus.mem_write   = 1'b0;
        if (state_q == RUN) begin
            bus.mem_address = bus.cpu_address;
            bus.mem_data_in = bus.cpu_data_in;
            bus.mem_write   = bus.cpu_write;
        end else if (state_q == LOAD) begin
            bus.mem_write = beat;
        end
    end

    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.host_ready   = host_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cpu_data_out = bus.mem_data_out;

endmodule

// File: tb/tb_spm_boot_loader.sv
// tb/tb_spm_boot_loader.sv - directed bench for spm_boot_loader with a behavioural SRAM
module tb_spm_boot_loader;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   wr_cnt;
    int   wr0;
    logic [7:0] sram [256];

    spm_boot_loader_if #(.word_size(8)) bus ();

    spm_boot_loader #(.word_size(8), .RELEASE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_data_out = sram[bus.mem_address];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            sram[bus.mem_address] <= bus.mem_data_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [7:0] base, input logic [7:0] len);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_len   = len;
        step();
        bus.load_start = 1'b0;
    endtask

    logic [7:0] t2d [4];
    logic [4:0] t3p;
    logic [7:0] t3a [3];
    int k;

    initial begin
        n_checks = 0;
        n_errors = 0;
        wr_cnt   = 0;
        for (int i = 0; i < 256; i++) sram[i] = 8'h00;
        t2d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        t3a = '{8'hFE, 8'hFF, 8'h00};
        t3p = 5'b10101;
        bus.load_start  = 1'b0;
        bus.load_base   = 8'h00;
        bus.load_len    = 8'h00;
        bus.host_data   = 8'h00;
        bus.host_valid  = 1'b0;
        bus.cpu_address = 8'h00;
        bus.cpu_data_in = 8'h00;
        bus.cpu_write   = 1'b0;
        rst = 1'b0;
        step(2);

        // 1: reset and idle
        check("rst_cpu_rst", bus.cpu_rst, 0);
        check("rst_host_ready", bus.host_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b1;
        step(20);
        check("idle_cpu_rst", bus.cpu_rst, 0);
        check("idle_host_ready", bus.host_ready, 0);
        check("idle_mem_write", bus.mem_write, 0);
        check("idle_no_writes", wr_cnt, 0);

        // 2: four words back-to-back at 0x00
        start_load(8'h00, 8'h04);
        check("t2_host_ready", bus.host_ready, 1);
        check("t2_busy", bus.busy, 1);
        check("t2_cpu_rst_held", bus.cpu_rst, 0);
        for (int i = 0; i < 4; i++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = t2d[i];
            #1;
            check("t2_mem_write", bus.mem_write, 1);
            check("t2_mem_address", bus.mem_address, i);
            step();
        end
        bus.host_valid = 1'b0;
        check("t2_rel_host_ready", bus.host_ready, 0);
        check("t2_rel_busy", bus.busy, 1);
        check("t2_rel_cpu_rst1", bus.cpu_rst, 0);
        step();
        check("t2_rel_cpu_rst2", bus.cpu_rst, 0);
        step();
        check("t2_run_cpu_rst", bus.cpu_rst, 1);
        check("t2_run_done", bus.done, 1);
        check("t2_run_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) check("t2_sram", sram[i], t2d[i]);

        // 3: gapped host stream wrapping past 0xFF
        wr0 = wr_cnt;
        start_load(8'hFE, 8'h03);
        k = 0;
        for (int i = 4; i >= 0; i--) begin
            bus.host_valid = t3p[i];
            bus.host_data  = 8'h31 + 8'(k);
            #1;
            check("t3_mem_write", bus.mem_write, t3p[i]);
            if (t3p[i]) check("t3_mem_address", bus.mem_address, t3a[k]);
            step();
            if (t3p[i]) k++;
        end
        bus.host_valid = 1'b0;
        check("t3_write_count", wr_cnt - wr0, 3);
        check("t3_sram_fe", sram[8'hFE], 8'h31);
        check("t3_sram_ff", sram[8'hFF], 8'h32);
        check("t3_sram_00", sram[8'h00], 8'h33);
        step(2);
        check("t3_done", bus.done, 1);

        // 4: reload while the core is writing
        bus.cpu_address = 8'h10;
        bus.cpu_data_in = 8'h55;
        bus.cpu_write   = 1'b1;
        #1;
        check("t4_core_write", bus.mem_write, 1);
        check("t4_core_addr", bus.mem_address, 8'h10);
        check("t4_core_data", bus.mem_data_in, 8'h55);
        step();
        check("t4_sram_core", sram[8'h10], 8'h55);
        bus.load_start = 1'b1;
        bus.load_base  = 8'h10;
        bus.load_len   = 8'h01;
        #1;
        check("t4_core_owns_start", bus.mem_write, 1);
        step();
        bus.load_start = 1'b0;
        wr0 = wr_cnt;
        check("t4_cpu_rst_drop", bus.cpu_rst, 0);
        check("t4_host_ready", bus.host_ready, 1);
        check("t4_core_blocked", bus.mem_write, 0);
        bus.host_valid = 1'b1;
        bus.host_data  = 8'h99;
        #1;
        check("t4_load_data", bus.mem_data_in, 8'h99);
        step();
        bus.host_valid = 1'b0;
        check("t4_rel_blocked", bus.mem_write, 0);
        step();
        check("t4_rel_cpu_rst", bus.cpu_rst, 0);
        check("t4_sram_load", sram[8'h10], 8'h99);
        step();
        check("t4_restart", bus.cpu_rst, 1);
        check("t4_write_count", wr_cnt - wr0, 1);
        check("t4_core_owns_again", bus.mem_write, 1);
        bus.cpu_write = 1'b0;

        // 5: zero-length load from IDLE
        rst = 1'b0;
        #1;
        check("t5_async_rst", bus.cpu_rst, 0);
        step();
        rst = 1'b1;
        step();
        wr0 = wr_cnt;
        start_load(8'h40, 8'h00);
        check("t5_busy", bus.busy, 1);
        check("t5_host_ready", bus.host_ready, 0);
        check("t5_cpu_rst1", bus.cpu_rst, 0);
        step();
        check("t5_cpu_rst2", bus.cpu_rst, 0);
        step();
        check("t5_run", bus.cpu_rst, 1);
        check("t5_done", bus.done, 1);
        check("t5_no_writes", wr_cnt - wr0, 0);

        // 6: reset in the middle of a load
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        start_load(8'h20, 8'h05);
        bus.host_valid = 1'b1;
        bus.host_data  = 8'h11;
        step();
        bus.load_start = 1'b1;
        bus.load_base  = 8'h80;
        bus.load_len   = 8'h01;
        bus.host_data  = 8'h22;
        #1;
        check("t6_start_ignored_addr", bus.mem_address, 8'h21);
        step();
        bus.load_start = 1'b0;
        check("t6_still_loading", bus.host_ready, 1);
        bus.host_data = 8'h33;
        #2;
        rst = 1'b0;
        #1;
        check("t6_host_ready", bus.host_ready, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_done", bus.done, 0);
        check("t6_cpu_rst", bus.cpu_rst, 0);
        check("t6_mem_write", bus.mem_write, 0);
        step();
        check("t6_sram_20", sram[8'h20], 8'h11);
        check("t6_sram_21", sram[8'h21], 8'h22);
        check("t6_sram_22", sram[8'h22], 8'h00);
        check("t6_sram_80", sram[8'h80], 8'h00);
        rst = 1'b1;
        bus.host_valid = 1'b0;
        step(2);
        check("t6_idle_ready", bus.host_ready, 0);
        check("t6_idle_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
